// File: rtl/mdu_unit.sv
// Multiply/divide unit owning HI/LO. Results are computed at accept time and held
// in pending registers until the cycle counter expires, then committed to HI/LO.
module mdu_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           r_state, w_state_nxt;
  logic [CntW-1:0]  r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_hi, r_lo, w_hi_nxt, w_lo_nxt;
  logic [WIDTH-1:0] r_pend_hi, r_pend_lo, w_pend_hi_nxt, w_pend_lo_nxt;

  // Operation decode
  logic w_is_mul, w_is_div, w_signed;
  logic [WIDTH-1:0] w_res_hi, w_res_lo;

  // Arithmetic datapath
  logic [2*WIDTH-1:0] w_a_ext, w_b_ext, w_prod, w_acc;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_b_safe, w_q_mag, w_r_mag, w_quot, w_rem;

  // Decode the op class and signedness
  always_comb begin
    w_is_mul = (op == 4'd1) || (op == 4'd2) || (op >= 4'd7 && op <= 4'd10);
    w_is_div = (op == 4'd3) || (op == 4'd4);
    w_signed = (op == 4'd1) || (op == 4'd3) || (op == 4'd7) || (op == 4'd9);
  end

  // Compute the pending result for the op presented this cycle
  always_comb begin
    // Sign- or zero-extend to 2*WIDTH; the truncated product is then correct either way
    w_a_ext = {{WIDTH{w_signed & a[WIDTH-1]}}, a};
    w_b_ext = {{WIDTH{w_signed & b[WIDTH-1]}}, b};
    w_prod  = w_a_ext * w_b_ext;
    w_acc   = {r_hi, r_lo};

    // Signed division via magnitudes; -2^(W-1)/-1 falls out as 0x80..0 with remainder 0
    w_a_neg  = w_signed & a[WIDTH-1];
    w_b_neg  = w_signed & b[WIDTH-1];
    w_a_mag  = w_a_neg ? (~a + 1'b1) : a;
    w_b_mag  = w_b_neg ? (~b + 1'b1) : b;
    w_b_safe = (w_b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : w_b_mag;
    w_q_mag  = w_a_mag / w_b_safe;
    w_r_mag  = w_a_mag % w_b_safe;
    w_quot   = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 1'b1) : w_q_mag;
    w_rem    = w_a_neg ? (~w_r_mag + 1'b1) : w_r_mag;

    w_res_hi = r_hi;
    w_res_lo = r_lo;
    case (op)
      4'd1, 4'd2: {w_res_hi, w_res_lo} = w_prod;
      4'd7, 4'd8: {w_res_hi, w_res_lo} = w_acc + w_prod;
      4'd9, 4'd10: {w_res_hi, w_res_lo} = w_acc - w_prod;
      4'd3, 4'd4: begin
        // Divide by zero leaves HI/LO untouched
        if (b != '0) begin
          w_res_hi = w_rem;
          w_res_lo = w_quot;
        end
      end
      default: ;
    endcase
  end

  // Next-state logic: accept in IDLE, count down and commit in RUN
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_pend_hi_nxt = r_pend_hi;
    w_pend_lo_nxt = r_pend_lo;
    case (r_state)
      StIdle: begin
        if (start) begin
          if (w_is_mul || w_is_div) begin
            w_pend_hi_nxt = w_res_hi;
            w_pend_lo_nxt = w_res_lo;
            w_cnt_nxt     = w_is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
            w_state_nxt   = StRun;
          end else if (op == 4'd5) begin
            w_hi_nxt = a;
          end else if (op == 4'd6) begin
            w_lo_nxt = a;
          end
        end
      end
      StRun: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CntW'(1)) begin
          w_hi_nxt    = r_pend_hi;
          w_lo_nxt    = r_pend_lo;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_pend_hi <= w_pend_hi_nxt;
      r_pend_lo <= w_pend_lo_nxt;
    end
  end

  assign busy = (r_state == StRun);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: expected HI/LO and busy length are queued when an
// op is driven and compared when busy drops.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_unit #(
    .WIDTH      (32),
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour, written from the arithmetic definitions
  task automatic model(input logic [3:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                       output logic [31:0] rhi, output logic [31:0] rlo);
    longint      sp;
    logic [63:0] up, acc;
    rhi = m_hi;
    rlo = m_lo;
    sp  = longint'($signed(ma)) * longint'($signed(mb));
    up  = {32'd0, ma} * {32'd0, mb};
    acc = {m_hi, m_lo};
    case (mop)
      4'd1: {rhi, rlo} = sp;
      4'd2: {rhi, rlo} = up;
      4'd7: {rhi, rlo} = acc + 64'(sp);
      4'd8: {rhi, rlo} = acc + up;
      4'd9: {rhi, rlo} = acc - 64'(sp);
      4'd10: {rhi, rlo} = acc - up;
      4'd3: if (mb != 0) begin
        rlo = $signed(ma) / $signed(mb);
        rhi = $signed(ma) % $signed(mb);
      end
      4'd4: if (mb != 0) begin
        rlo = ma / mb;
        rhi = ma % mb;
      end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
  endtask

  // Single-cycle op with no busy phase (mthi/mtlo/invalid); caller is at posedge+1
  task automatic quick_op(input logic [3:0] qop, input logic [31:0] qa);
    start = 1'b1;
    op    = qop;
    a     = qa;
    @(posedge clk);
    #1 start = 1'b0;
    op = 4'd0;
    if (qop == 4'd5) m_hi = qa;
    if (qop == 4'd6) m_lo = qa;
    check_eq("quick_busy", busy, 0);
    check_eq("quick_hi", hi, m_hi);
    check_eq("quick_lo", lo, m_lo);
  endtask

  // mode 0: plain, 1: inject mtlo at busy cycle inj_at, 2: pulse reset at busy cycle inj_at
  task automatic run_op(input logic [3:0] rop, input logic [31:0] ra, input logic [31:0] rb,
                        input logic [31:0] ehi, input logic [31:0] elo, input int ecyc,
                        input int mode, input int inj_at);
    exp_t e;
    int   cnt;
    e.hi  = ehi;
    e.lo  = elo;
    e.cyc = ecyc;
    sb_q.push_back(e);
    start = 1'b1;
    op    = rop;
    a     = ra;
    b     = rb;
    @(posedge clk);
    #1 start = 1'b0;
    op  = 4'd0;
    cnt = 0;
    while (busy && cnt < 64) begin
      cnt++;
      check_eq("hold_hi", hi, m_hi);
      check_eq("hold_lo", lo, m_lo);
      if (mode == 1 && cnt == inj_at) begin
        start = 1'b1;
        op    = 4'd6;
        a     = 32'h0000AAAA;
      end
      if (mode == 2 && cnt == inj_at) reset = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      op    = 4'd0;
      reset = 1'b1;
    end
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check_eq("busy_cycles", 64'(cnt), 64'(e.cyc));
      check_eq("res_hi", hi, e.hi);
      check_eq("res_lo", lo, e.lo);
      m_hi = e.hi;
      m_lo = e.lo;
    end
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb, ehi, elo;
    logic [3:0]  ops [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10};

    do_reset();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_hi", hi, 0);
    check_eq("rst_lo", lo, 0);

    run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5, 0, 0);
    run_op(4'd1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 5, 0, 0);
    run_op(4'd7, 32'd2, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFF1, 5, 0, 0);
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 0, 0);
    run_op(4'd4, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC, 10, 0, 0);

    // Undefined op must not disturb anything
    quick_op(4'd11, 32'hDEADBEEF);

    do_reset();
    quick_op(4'd5, 32'h12345678);
    run_op(4'd3, 32'd5, 32'd0, 32'h12345678, 32'h00000000, 10, 0, 0);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, 0, 0);
    quick_op(4'd6, 32'h00000055);

    // mtlo during RUN is ignored
    run_op(4'd1, 32'd4, 32'd5, 32'd0, 32'd20, 5, 1, 3);

    // Reset mid-division aborts; nothing commits afterwards
    run_op(4'd3, 32'd100, 32'd7, 32'd0, 32'd0, 4, 2, 4);
    repeat (12) @(posedge clk);
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_hi", hi, 0);
    check_eq("abort_lo", lo, 0);
    run_op(4'd2, 32'd3, 32'd3, 32'd0, 32'd9, 5, 0, 0);

    // Random ops against the reference model
    for (int i = 0; i < 12; i++) begin
      rop = ops[$urandom_range(0, 7)];
      ra  = $urandom;
      rb  = $urandom;
      if (rb == 0) rb = 32'd1;
      if (rop == 4'd3 && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
      model(rop, ra, rb, ehi, elo);
      run_op(rop, ra, rb, ehi, elo, (rop == 4'd3 || rop == 4'd4) ? 10 : 5, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
